// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-core bus arbiter: FSM states, grant/request
// levels and owner identifiers.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN1 = 2'd1,
    ST_OWN2 = 2'd2,
    ST_TURN = 2'd3
  } bus_state_e;

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_e;

  localparam logic BUS_GRANTED       = 1'b1;
  localparam logic BUS_NOT_GRANTED   = 1'b0;
  localparam logic BUS_REQUESTED     = 1'b1;
  localparam logic BUS_NOT_REQUESTED = 1'b0;

  function automatic logic is_owned(input bus_state_e s);
    return (s == ST_OWN1) || (s == ST_OWN2);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Hold-time counter for one bus ownership: cleared on entry, counts each owned
// cycle and flags the last permitted cycle.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc_o = (count_q == CNT_LAST);

  // Saturates at the terminal value so it never wraps while the bus is idle.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !tc_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bus_scheduler.sv
// Two-core bus arbiter: alternating priority on contention, owner-driven release,
// hold timeout and a one-cycle turnaround between grants. All outputs registered.
module bus_scheduler
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic request_p1,
  input  logic request_p2,
  input  logic done_p1,
  input  logic done_p2,
  output logic grant1,
  output logic grant2,
  output logic bus_busy,
  output logic timeout_err
);

  bus_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       ready_q;
  logic       grant1_q, grant1_d;
  logic       grant2_q, grant2_d;
  logic       busy_q, busy_d;
  logic       timeout_err_q, timeout_err_d;
  logic       cnt_clr, cnt_inc, cnt_tc;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  assign cnt_clr = is_owned(state_d) && !is_owned(state_q);
  assign cnt_inc = is_owned(state_q);

  // ready_q holds off arbitration for the first edge after reset release.
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && enable) begin
          if (request_p1 == BUS_REQUESTED && request_p2 == BUS_REQUESTED) begin
            if (last_owner_q == OWNER_P2) begin
              state_d      = ST_OWN1;
              last_owner_d = OWNER_P1;
            end else begin
              state_d      = ST_OWN2;
              last_owner_d = OWNER_P2;
            end
          end else if (request_p1 == BUS_REQUESTED) begin
            state_d      = ST_OWN1;
            last_owner_d = OWNER_P1;
          end else if (request_p2 == BUS_REQUESTED) begin
            state_d      = ST_OWN2;
            last_owner_d = OWNER_P2;
          end
        end
      end
      ST_OWN1: begin
        if (done_p1 || request_p1 == BUS_NOT_REQUESTED || cnt_tc) begin
          state_d       = ST_TURN;
          timeout_err_d = cnt_tc && !done_p1 && (request_p1 == BUS_REQUESTED);
        end
      end
      ST_OWN2: begin
        if (done_p2 || request_p2 == BUS_NOT_REQUESTED || cnt_tc) begin
          state_d       = ST_TURN;
          timeout_err_d = cnt_tc && !done_p2 && (request_p2 == BUS_REQUESTED);
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    grant1_d = (state_d == ST_OWN1) ? BUS_GRANTED : BUS_NOT_GRANTED;
    grant2_d = (state_d == ST_OWN2) ? BUS_GRANTED : BUS_NOT_GRANTED;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_owner_q  <= OWNER_P2;
      ready_q       <= 1'b0;
      grant1_q      <= BUS_NOT_GRANTED;
      grant2_q      <= BUS_NOT_GRANTED;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      ready_q       <= 1'b1;
      grant1_q      <= grant1_d;
      grant2_q      <= grant2_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant1      = grant1_q;
  assign grant2      = grant2_q;
  assign bus_busy    = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/bus_scheduler.md
BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles one core may hold the bus; legal range 2..1024.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: permits new grants while high.
REQ-005 The block SHALL have port request_p1, input, 1 bit: bus request from core P1.
REQ-006 The block SHALL have port request_p2, input, 1 bit: bus request from core P2.
REQ-007 The block SHALL have port done_p1, input, 1 bit: P1 ends its transaction this cycle.
REQ-008 The block SHALL have port done_p2, input, 1 bit: P2 ends its transaction this cycle.
REQ-009 The block SHALL have port grant1, output, 1 bit: P1 owns the bus.
REQ-010 The block SHALL have port grant2, output, 1 bit: P2 owns the bus.
REQ-011 The block SHALL have port bus_busy, output, 1 bit: the bus is owned or in turnaround.
REQ-012 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when an ownership is ended by timeout.

Function
REQ-013 The FSM SHALL have states IDLE, OWN1, OWN2 and TURN; all outputs SHALL be registered.
REQ-014 In IDLE with enable=1 and exactly one request high, the FSM SHALL enter that requester's OWN state, so its grant is high on the next cycle (latency 1).
REQ-015 In IDLE with enable=1 and both requests high, the FSM SHALL grant the core other than last_owner, then update last_owner to the core just granted.
REQ-016 last_owner SHALL reset to P2, so P1 wins the first contested arbitration.
REQ-017 In IDLE with enable=0 or no request, the FSM SHALL stay in IDLE with both grants low.
REQ-018 In OWNx, the grant SHALL stay high until done_px=1, request_px=0 or a timeout occurs; any of these SHALL cause a transition to TURN.
REQ-019 The done_px and request_px inputs of the core that does not own the bus SHALL be ignored.
REQ-020 Deasserting enable during OWNx SHALL NOT preempt the owner; it blocks only the next grant.
REQ-021 TURN SHALL last exactly one cycle with both grants low, then go to IDLE, giving a minimum gap of 2 cycles between grants.
REQ-022 The hold counter SHALL clear on entry to OWNx and increment each OWN cycle; its width SHALL be clog2(TIMEOUT_CYCLES).
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 without done_px or a request drop, the FSM SHALL exit to TURN and timeout_err SHALL pulse high for exactly the TURN cycle.
REQ-024 If done_px and the timeout coincide, the exit SHALL count as normal completion and timeout_err SHALL stay 0.
REQ-025 {grant1, grant2} SHALL never be 2'b11.
REQ-026 bus_busy SHALL be 1 in OWN1, OWN2 and TURN, and 0 in IDLE.

Reset
REQ-027 While reset=0, grant1, grant2, bus_busy and timeout_err SHALL be 0 and the state SHALL be IDLE, asynchronously and including mid-transaction.
REQ-028 While reset=0, the counter SHALL be 0 and last_owner SHALL be P2.
REQ-029 Reset release SHALL take effect on the first rising clk edge with reset=1; the first grant is possible on the following edge.

Structure
REQ-030 The state encoding, the BUS_GRANTED/BUS_NOT_GRANTED and BUS_REQUESTED/BUS_NOT_REQUESTED constants, and the P1/P2 owner encoding SHALL live in shared package bus_arb_pkg.
REQ-031 The hold counter, with its clear, increment and terminal-count flag, SHALL be the single sub-module timeout_counter; the FSM stays in bus_scheduler.

Verification
REQ-032 The bench SHALL cover: reset released, enable=1, request_p1=1 only -> grant1=1 one cycle later; done_p1 after 5 cycles -> TURN for 1 cycle, then IDLE.
REQ-033 The bench SHALL cover: both requests held, done pulsed every 4 cycles -> grants alternate P1, P2, P1, P2 with a 2-cycle gap each time.
REQ-034 The bench SHALL cover: TIMEOUT_CYCLES=8, P2 holds the bus without done -> grant2 drops after 8 cycles, timeout_err=1 for 1 cycle, and the next contested grant goes to P1.
REQ-035 The bench SHALL cover: enable=0 during OWN1 -> grant1 holds until done_p1; with enable still 0, a pending request_p2 is not granted until enable=1.
REQ-036 The bench SHALL cover: reset asserted mid-OWN2 -> grant2=0 immediately without waiting for a clk edge; after release, a contested request grants P1.
REQ-037 The bench SHALL cover: done_p1 coinciding with the timeout cycle -> timeout_err stays 0; a random-stimulus run of 10k cycles -> {grant1, grant2} never equals 11.
